bus_arbiter_mux: RTL and testbench
==================================

# bus_arbiter_mux

Parametrised, registered successor to the combinational bus select path. It accepts request lines from N bus sources and grants exactly one per cycle, by fixed priority or round-robin. The granted source's data drives a registered bus word one cycle later, along with its one-hot grant and encoded index. It also flags and counts multi-request conflicts, and sits between the datapath register outputs and the shared CPU bus.

## Interface
- `WIDTH`, default 32: bus word width in bits.
- `SOURCES`, default 24: number of bus sources; legal range 2..32.
- `SEL_W`, default 5: grant index width; must equal ceil(log2(SOURCES)).
- `clock` input, 1 bit: single clock; all state updates on the rising edge.
- `clear` input, 1 bit: one clock; reset is synchronous and active-high.
- `src_data` input, SOURCES*WIDTH bits: packed source words; source i occupies bits [i*WIDTH +: WIDTH].
- `src_req` input, SOURCES bits: bit i high means source i requests the bus this cycle.
- `mode` input, 1 bit: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round-robin.
- `hold` input, 1 bit: stall; when high, all registered state is frozen.
- `bus_out` output, WIDTH bits: registered bus word.
- `bus_valid` output, 1 bit: `bus_out` was loaded from a granted source on the last active edge.
- `grant` output, SOURCES bits: registered one-hot grant; all zero when idle.
- `grant_idx` output, SEL_W bits: registered encoded index of the last granted source.
- `conflict` output, 1 bit: registered pulse; more than one request was seen on the last active edge.
- `conflict_count` output, 8 bits: saturating count of conflict cycles.

## Operation
- Winner selection is combinational, from the current `src_req`, `mode` and internal `rr_ptr` (SEL_W bits, index of the last round-robin grant).
- Priority mode: the winner is the lowest set index of `src_req`.
- Round-robin mode:
  - Search indices rr_ptr+1, rr_ptr+2, …, wrapping at SOURCES-1 to 0, ending at rr_ptr.
  - The first set bit wins.
  - A sole requester at rr_ptr is granted again.
- Active edge (`hold`=0, `clear`=0) with any request:
  - `bus_out` ← src_data[winner]
  - `bus_valid` ← 1
  - `grant` ← one-hot(winner)
  - `grant_idx` ← winner
  - `rr_ptr` ← winner, in both modes, so a later mode switch continues fairly.
- Active edge with no request:
  - `bus_valid` ← 0 and `grant` ← 0.
  - `bus_out`, `grant_idx` and `rr_ptr` hold.
- Conflict:
  - `conflict` ← 1 when popcount(src_req) ≥ 2, else 0.
  - `conflict_count` increments on each such edge and saturates at 255; it never wraps.
- `hold`=1: every register, including `conflict` and `conflict_count`, retains its value; inputs are ignored.
- `clear`=1 on an edge:
  - `bus_out`=0, `bus_valid`=0, `grant`=0, `grant_idx`=0, `conflict`=0, `conflict_count`=0.
  - `rr_ptr`=SOURCES-1, so the first round-robin search starts at index 0.
  - `clear` overrides `hold`.
  - `clear` during a stream discards the in-flight selection; there is no partial update.
- Request bits at index ≥ SOURCES do not exist; `src_data` is not inspected for non-granted sources.

## Timing
- Latency: one cycle from `src_req`/`src_data` sampled at edge k to `bus_out`/`grant`/`bus_valid` valid after edge k.
- Throughput: one grant per cycle; no bubble between consecutive grants, including to the same source.
- A `mode` change applies to the selection made at the very next active edge, using the current `rr_ptr`.
- All outputs are register-driven; there is no combinational path from inputs to outputs.
- After `hold` deasserts, the first active edge evaluates that cycle's inputs; no stale request is replayed.

## Test plan
- **Reset values:** drive `clear`=1 for 2 cycles with random requests → all outputs 0 after each edge; first RR grant afterwards with `src_req`=all ones is index 0.
- **Priority with conflict:** `mode`=0, `src_req` bits 3, 7, 20 set, src_data[3]=0xDEADBEEF → next cycle `bus_out`=0xDEADBEEF, `grant`=1<<3, `grant_idx`=3, `conflict`=1, `conflict_count`=1.
- **Round-robin rotation:** `mode`=1, bits 3, 7, 20 held set for 4 cycles → `grant_idx` sequence 3, 7, 20, 3, with no idle cycles.
- **Idle hold:** grant source 5 (data 0x12345678), then `src_req`=0 → `bus_valid`=0, `grant`=0, `bus_out`=0x12345678, `grant_idx`=5.
- **Stall and clear override:** `hold`=1 for 3 cycles with changing requests → outputs unchanged; `hold`=1 with `clear`=1 → all outputs 0.
- **Counter saturation:** 300 consecutive two-request cycles → `conflict_count` reaches 255 and stays at 255, with `conflict`=1 each cycle.

Source files
------------

// File: rtl/bus_arbiter_mux.sv
// -----------------------------------------------------------------------------
// bus_arbiter_mux
//
// Registered bus arbiter and multiplexer. It picks one requesting source per
// cycle, by fixed priority (lowest index wins) or by round-robin. One cycle
// later it presents that source's data word on the shared bus, together with
// the one-hot grant and the encoded grant index. It also flags cycles with
// more than one requester and keeps a saturating count of them.
//
// Parameters
//   WIDTH    bus word width in bits
//   SOURCES  number of bus sources, legal range 2..32
//   SEL_W    grant index width, must equal ceil(log2(SOURCES))
//
// Ports
//   clock           single clock; all state changes on the rising edge
//   clear           synchronous active-high reset; overrides hold
//   src_data        packed source words, source i at [i*WIDTH +: WIDTH]
//   src_req         per-source request lines
//   mode            0 = fixed priority, 1 = round-robin
//   hold            stall; freezes every register while high
//   bus_out         registered bus word
//   bus_valid       bus_out was loaded from a granted source on the last edge
//   grant           registered one-hot grant, all zero when idle
//   grant_idx       registered index of the last granted source
//   conflict        registered flag: two or more requests on the last edge
//   conflict_count  saturating count of conflict cycles (stops at 255)
// -----------------------------------------------------------------------------
module bus_arbiter_mux #(
  parameter int WIDTH   = 32,
  parameter int SOURCES = 24,
  parameter int SEL_W   = 5
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [SOURCES*WIDTH-1:0]   src_data,
  input  logic [SOURCES-1:0]         src_req,
  input  logic                       mode,
  input  logic                       hold,
  output logic [WIDTH-1:0]           bus_out,
  output logic                       bus_valid,
  output logic [SOURCES-1:0]         grant,
  output logic [SEL_W-1:0]           grant_idx,
  output logic                       conflict,
  output logic [7:0]                 conflict_count
);

  typedef enum logic {
    ARB_PRIORITY    = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_e;

  // Round-robin pointer value after clear: the last index, so the first
  // round-robin search begins at index 0.
  localparam logic [SEL_W-1:0] RR_PTR_INIT = SEL_W'(SOURCES - 1);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   bus_q;
  logic               bus_valid_q;
  logic [SOURCES-1:0] grant_q;
  logic [SEL_W-1:0]   grant_idx_q;
  logic               conflict_q;
  logic [7:0]         conflict_count_q;
  logic [SEL_W-1:0]   rr_ptr_q;   // index of the most recent grant

  // ---------------------------------------------------------------------------
  // Next-state / selection signals
  // ---------------------------------------------------------------------------
  arb_mode_e          arb_mode;
  logic               any_req;
  logic               multi_req;
  logic [SOURCES-1:0] upper_req;  // requests strictly above rr_ptr_q
  logic [SEL_W-1:0]   winner_d;
  logic [SOURCES-1:0] grant_d;
  logic [WIDTH-1:0]   bus_d;
  logic [7:0]         conflict_count_d;

  // Index of the lowest set bit; zero when the vector is empty (callers only
  // use the result when at least one bit is set).
  function automatic logic [SEL_W-1:0] lowest_set(input logic [SOURCES-1:0] vec);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (vec[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  assign arb_mode = arb_mode_e'(mode);
  assign any_req  = |src_req;

  // Clearing the lowest set bit leaves something behind only when two or more
  // bits were set, which is cheaper than a full popcount.
  assign multi_req = |(src_req & (src_req - SOURCES'(1)));

  // ---------------------------------------------------------------------------
  // Winner selection
  //
  // Round-robin is split into two fixed-priority searches: first among the
  // requesters above rr_ptr_q, and if there are none, among all requesters.
  // The second search naturally covers the wrap from SOURCES-1 to 0 and ends
  // at rr_ptr_q itself, so a sole requester at the pointer is granted again.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    upper_req = '0;
    winner_d  = '0;
    for (int i = 0; i < SOURCES; i++) begin
      upper_req[i] = src_req[i] && (SEL_W'(i) > rr_ptr_q);
    end
    if (arb_mode == ARB_ROUND_ROBIN && (|upper_req)) begin
      winner_d = lowest_set(upper_req);
    end else begin
      winner_d = lowest_set(src_req);
    end
  end

  // One-hot grant, all zero when nobody requests.
  assign grant_d = any_req ? (SOURCES'(1) << winner_d) : '0;

  // AND-OR multiplexer keyed by the one-hot grant; non-granted words are
  // masked off and never influence the result.
  always_comb begin
    bus_d = '0;
    for (int i = 0; i < SOURCES; i++) begin
      bus_d = bus_d | ({WIDTH{grant_d[i]}} & src_data[i*WIDTH +: WIDTH]);
    end
  end

  // Saturating conflict counter: it sticks at 255 instead of wrapping.
  always_comb begin
    conflict_count_d = conflict_count_q;
    if (multi_req && (conflict_count_q != 8'hFF)) begin
      conflict_count_d = conflict_count_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  //
  // clear wins over hold. While hold is high nothing changes, so the first
  // edge after hold drops evaluates that cycle's inputs, not old ones.
  // On an idle edge only bus_valid, grant and conflict update; the bus word,
  // index and round-robin pointer keep their last values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (clear) begin
      bus_q            <= '0;
      bus_valid_q      <= 1'b0;
      grant_q          <= '0;
      grant_idx_q      <= '0;
      conflict_q       <= 1'b0;
      conflict_count_q <= '0;
      rr_ptr_q         <= RR_PTR_INIT;
    end else if (!hold) begin
      bus_valid_q      <= any_req;
      grant_q          <= grant_d;
      conflict_q       <= multi_req;
      conflict_count_q <= conflict_count_d;
      if (any_req) begin
        bus_q       <= bus_d;
        grant_idx_q <= winner_d;
        // The pointer follows the winner in both modes, so a later switch to
        // round-robin carries on fairly from the most recent grant.
        rr_ptr_q    <= winner_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: register-driven only
  // ---------------------------------------------------------------------------
  assign bus_out        = bus_q;
  assign bus_valid      = bus_valid_q;
  assign grant          = grant_q;
  assign grant_idx      = grant_idx_q;
  assign conflict       = conflict_q;
  assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_mux
//
// Directed bench for bus_arbiter_mux at its default parameters. Inputs change
// 1 ns after a rising edge and outputs are sampled at that same point, well
// away from the next edge. Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_mux;

  localparam int WIDTH   = 32;
  localparam int SOURCES = 24;
  localparam int SEL_W   = 5;

  logic                     clock;
  logic                     clear;
  logic [SOURCES*WIDTH-1:0] src_data;
  logic [SOURCES-1:0]       src_req;
  logic                     mode;
  logic                     hold;
  logic [WIDTH-1:0]         bus_out;
  logic                     bus_valid;
  logic [SOURCES-1:0]       grant;
  logic [SEL_W-1:0]         grant_idx;
  logic                     conflict;
  logic [7:0]               conflict_count;

  int checks;
  int failures;

  bus_arbiter_mux #(
    .WIDTH   (WIDTH),
    .SOURCES (SOURCES),
    .SEL_W   (SEL_W)
  ) dut (
    .clock          (clock),
    .clear          (clear),
    .src_data       (src_data),
    .src_req        (src_req),
    .mode           (mode),
    .hold           (hold),
    .bus_out        (bus_out),
    .bus_valid      (bus_valid),
    .grant          (grant),
    .grant_idx      (grant_idx),
    .conflict       (conflict),
    .conflict_count (conflict_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag,
                               input logic [31:0] e_bus,
                               input logic        e_valid,
                               input logic [63:0] e_grant,
                               input int          e_idx,
                               input logic        e_conf,
                               input int          e_cnt);
    check({tag, ".bus_out"},        64'(bus_out),        64'(e_bus));
    check({tag, ".bus_valid"},      64'(bus_valid),      64'(e_valid));
    check({tag, ".grant"},          64'(grant),          e_grant);
    check({tag, ".grant_idx"},      64'(grant_idx),      64'(e_idx));
    check({tag, ".conflict"},       64'(conflict),       64'(e_conf));
    check({tag, ".conflict_count"}, 64'(conflict_count), 64'(e_cnt));
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    src_data[i*WIDTH +: WIDTH] = v;
  endtask

  function automatic logic [63:0] oh(input int i);
    return 64'(1) << i;
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear    = 1'b1;
    hold     = 1'b0;
    mode     = 1'b0;
    src_req  = '0;
    src_data = '0;

    // ---- Reset: two clear edges with random traffic, all outputs zero ----
    for (int c = 0; c < 2; c++) begin
      src_req = SOURCES'($urandom);
      mode    = 1'($urandom);
      for (int i = 0; i < SOURCES; i++) set_word(i, $urandom);
      step();
      check_outputs($sformatf("reset%0d", c), 32'h0, 1'b0, 64'h0, 0, 1'b0, 0);
    end

    // First round-robin grant after clear with every source requesting: 0.
    clear   = 1'b0;
    mode    = 1'b1;
    src_req = '1;
    set_word(0, 32'hC0FFEE00);
    step();
    check_outputs("rr_first", 32'hC0FFEE00, 1'b1, oh(0), 0, 1'b1, 1);

    // ---- Priority mode with a three-way conflict ----
    do_clear();
    mode    = 1'b0;
    src_req = '0;
    src_req[3] = 1'b1; src_req[7] = 1'b1; src_req[20] = 1'b1;
    set_word(3, 32'hDEADBEEF);
    set_word(7, 32'h77777777);
    set_word(20, 32'h20202020);
    step();
    check_outputs("prio", 32'hDEADBEEF, 1'b1, oh(3), 3, 1'b1, 1);

    // ---- Round-robin rotation over 3, 7, 20 with no idle cycles ----
    do_clear();
    for (int i = 0; i < SOURCES; i++) set_word(i, 32'hA0000000 | 32'(i));
    mode = 1'b1;
    step();
    check_outputs("rr0", 32'hA0000003, 1'b1, oh(3), 3, 1'b1, 1);
    step();
    check_outputs("rr1", 32'hA0000007, 1'b1, oh(7), 7, 1'b1, 2);
    step();
    check_outputs("rr2", 32'hA0000014, 1'b1, oh(20), 20, 1'b1, 3);
    step();
    check_outputs("rr3", 32'hA0000003, 1'b1, oh(3), 3, 1'b1, 4);

    // ---- Mode switches use the current pointer (now 3) ----
    mode    = 1'b0;
    src_req = '0;
    src_req[3] = 1'b1; src_req[7] = 1'b1;
    step();
    check_outputs("sw_prio", 32'hA0000003, 1'b1, oh(3), 3, 1'b1, 5);
    mode = 1'b1;
    step();
    check_outputs("sw_rr", 32'hA0000007, 1'b1, oh(7), 7, 1'b1, 6);

    // Sole requester sitting at the pointer is granted again.
    src_req = '0;
    src_req[7] = 1'b1;
    step();
    check_outputs("rr_sole", 32'hA0000007, 1'b1, oh(7), 7, 1'b0, 6);

    // Wrap from the top index back to a low one.
    src_req = '0;
    src_req[23] = 1'b1;
    step();
    check_outputs("rr_top", 32'hA0000017, 1'b1, oh(23), 23, 1'b0, 6);
    src_req[2] = 1'b1;
    step();
    check_outputs("rr_wrap", 32'hA0000002, 1'b1, oh(2), 2, 1'b1, 7);

    // ---- Idle: bus word and index hold, valid and grant drop ----
    mode    = 1'b0;
    src_req = '0;
    src_req[5] = 1'b1;
    set_word(5, 32'h12345678);
    step();
    check_outputs("idle_grant", 32'h12345678, 1'b1, oh(5), 5, 1'b0, 7);
    src_req = '0;
    set_word(5, 32'h0BADF00D);
    step();
    check_outputs("idle", 32'h12345678, 1'b0, 64'h0, 5, 1'b0, 7);

    // ---- Stall: three held cycles with changing inputs ----
    src_req = '0;
    src_req[9] = 1'b1; src_req[12] = 1'b1;
    step();
    check_outputs("pre_hold", 32'hA0000009, 1'b1, oh(9), 9, 1'b1, 8);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      src_req = (c == 0) ? SOURCES'(24'h000006) : (c == 1) ? SOURCES'(24'h000001) : '1;
      mode    = 1'(c);
      step();
      check_outputs($sformatf("hold%0d", c), 32'hA0000009, 1'b1, oh(9), 9, 1'b1, 8);
    end
    // First active edge after hold evaluates only the fresh request.
    hold    = 1'b0;
    mode    = 1'b0;
    src_req = '0;
    src_req[15] = 1'b1;
    step();
    check_outputs("post_hold", 32'hA000000F, 1'b1, oh(15), 15, 1'b0, 8);

    // clear overrides hold.
    hold    = 1'b1;
    clear   = 1'b1;
    src_req = '1;
    step();
    check_outputs("hold_clear", 32'h0, 1'b0, 64'h0, 0, 1'b0, 0);
    hold  = 1'b0;
    clear = 1'b0;

    // ---- Counter saturation over 300 two-request cycles ----
    mode    = 1'b0;
    src_req = '0;
    src_req[0] = 1'b1; src_req[1] = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      step();
      check($sformatf("sat%0d.conflict", k), 64'(conflict), 64'h1);
      check($sformatf("sat%0d.count", k), 64'(conflict_count), 64'((k < 255) ? k : 255));
    end
    src_req = '0;
    step();
    check_outputs("sat_idle", 32'hA0000000, 1'b0, 64'h0, 0, 1'b0, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
